// File: rtl/seq_mult_last2_acc.sv
// ============================================================================
// Module   : seq_mult_last2_acc
// Purpose  : Shift-add product of the last two accepted samples, with ignore
//            filter, valid/ready input and optional sticky-overflow accumulate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult_last2_acc #(
  parameter int             W   = 4,
  parameter logic [W-1:0]   IGN = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             ld,
  input  logic             acc,
  input  logic             clr,
  output logic [2*W-1:0]   out,
  output logic             out_valid,
  output logic             ovf
);

  localparam int              CW         = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0]   C_CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [W-1:0]     r_last;
  logic [W-1:0]     r_ignore;
  logic [2*W-1:0]   r_mcand;
  logic [W-1:0]     r_mplier;
  logic [2*W-1:0]   r_partial;
  logic [CW-1:0]    r_cnt;
  logic             r_acc_l;
  logic [2*W-1:0]   r_out;
  logic             r_out_valid;
  logic             r_ovf;

  logic             w_hs;
  logic             w_accept;
  logic [2*W:0]     w_sum;

  assign in_ready  = (r_state == S_IDLE);
  assign w_hs      = in_valid & in_ready;
  assign w_accept  = w_hs & ~ld & (in != r_ignore);
  assign w_sum     = {1'b0, r_out} + {1'b0, r_partial};

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign ovf       = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nx = S_MUL;
      S_MUL:   if (r_cnt == C_CNT_LAST) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (clr) w_state_nx = S_IDLE;
  end

  // Multiplicand shifts left and multiplier shifts right so that each step
  // only inspects multiplier bit 0 and adds mcand << cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= '0;
      r_ignore    <= IGN;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_partial   <= '0;
      r_cnt       <= '0;
      r_acc_l     <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (clr) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_hs && ld) begin
            r_ignore <= in;
          end else if (w_accept) begin
            r_mcand   <= {{W{1'b0}}, r_last};
            r_mplier  <= in;
            r_last    <= in;
            r_acc_l   <= acc;
            r_partial <= '0;
            r_cnt     <= '0;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) r_partial <= r_partial + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        S_DONE: begin
          if (r_acc_l) begin
            r_out <= w_sum[2*W-1:0];
            r_ovf <= r_ovf | w_sum[2*W];
          end else begin
            r_out <= r_partial;
          end
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_last2_acc.sv
// ============================================================================
// Module   : tb_seq_mult_last2_acc
// Purpose  : Directed bench for seq_mult_last2_acc, W=4/IGN=0 and W=6/IGN=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mult_last2_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  in4 = '0;
  logic [5:0]  in6 = '0;
  logic [1:0]  in_valid = '0, ld = '0, acc = '0, clr = '0;
  logic [1:0]  in_ready, out_valid, ovf;
  logic [7:0]  out4;
  logic [11:0] out6;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_mult_last2_acc #(.W(4), .IGN(4'd0)) u_dut4 (
    .clk(clk), .rst(rst), .in(in4), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .ld(ld[0]), .acc(acc[0]), .clr(clr[0]), .out(out4), .out_valid(out_valid[0]),
    .ovf(ovf[0])
  );

  seq_mult_last2_acc #(.W(6), .IGN(6'd8)) u_dut6 (
    .clk(clk), .rst(rst), .in(in6), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .ld(ld[1]), .acc(acc[1]), .clr(clr[1]), .out(out6), .out_valid(out_valid[1]),
    .ovf(ovf[1])
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks each instance at transaction level.
  longint m_last[2], m_ign[2], m_out[2], m_mc[2], m_mp[2];
  bit     m_ovf[2], m_accl[2], m_vexp[2];
  int     m_busy[2];

  function automatic int wk(input int k);
    return (k == 0) ? 4 : 6;
  endfunction

  function automatic longint in_of(input int k);
    return (k == 0) ? longint'(in4) : longint'(in6);
  endfunction

  function automatic longint out_of(input int k);
    return (k == 0) ? longint'(out4) : longint'(out6);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_last[k] = 0; m_ign[k] = (k == 0) ? 0 : 8; m_out[k] = 0; m_ovf[k] = 0;
        m_vexp[k] = 0; m_busy[k] = 0; m_accl[k] = 0; m_mc[k] = 0; m_mp[k] = 0;
      end else if (clr[k]) begin
        m_out[k] = 0; m_ovf[k] = 0; m_vexp[k] = 0; m_busy[k] = 0;
      end else begin
        m_vexp[k] = 0;
        if (m_busy[k] > 0) begin
          m_busy[k]--;
          if (m_busy[k] == 0) begin
            longint prod, s, lim;
            lim  = longint'(1) << (2 * wk(k));
            prod = m_mc[k] * m_mp[k];
            if (m_accl[k]) begin
              s = m_out[k] + prod;
              if (s >= lim) m_ovf[k] = 1;
              m_out[k] = s % lim;
            end else begin
              m_out[k] = prod;
            end
            m_vexp[k] = 1;
          end
        end else if (in_valid[k]) begin
          if (ld[k]) m_ign[k] = in_of(k);
          else if (in_of(k) != m_ign[k]) begin
            m_mc[k] = m_last[k]; m_mp[k] = in_of(k); m_last[k] = in_of(k);
            m_accl[k] = acc[k]; m_busy[k] = wk(k) + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("out_valid[%0d]", k), longint'(out_valid[k]), longint'(m_vexp[k]));
        check($sformatf("out[%0d]", k), out_of(k), m_out[k]);
        check($sformatf("ovf[%0d]", k), longint'(ovf[k]), longint'(m_ovf[k]));
        check($sformatf("in_ready[%0d]", k), longint'(in_ready[k]), longint'(m_busy[k] == 0));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int k, input int v, input bit l, input bit a);
    int n;
    if (k == 0) in4 = 4'(v); else in6 = 6'(v);
    ld[k] = l; acc[k] = a; in_valid[k] = 1'b1;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout[%0d]: in_ready stayed 0, required 1", k);
    end
    tick();
    in_valid[k] = 1'b0; ld[k] = 1'b0; acc[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = 1;
    tick();
    while (!out_valid[k] && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid[k]) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout[%0d]: out_valid stayed 0, required 1", k);
    end
  endtask

  task automatic pulse_clr(input int k);
    clr[k] = 1'b1;
    tick();
    clr[k] = 1'b0;
  endtask

  int lat;

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_out", longint'(out4), 0);
    check("reset_ovf", longint'(ovf[0]), 0);
    check("reset_ready", longint'(in_ready[0]), 1);

    send(0, 5, 0, 0);
    check("busy_ready", longint'(in_ready[0]), 0);
    wait_done(0, lat);
    check("latency_first", lat, 5);
    check("prod_0x5", longint'(out4), 0);
    send(0, 10, 0, 0);
    wait_done(0, lat);
    check("latency_second", lat, 5);
    check("prod_5x10", longint'(out4), 50);

    send(0, 0, 0, 0);
    check("drop_zero_ready", longint'(in_ready[0]), 1);
    send(0, 3, 0, 0);
    wait_done(0, lat);
    check("prod_10x3", longint'(out4), 30);

    send(0, 3, 1, 0);
    send(0, 3, 0, 0);
    check("drop_three_ready", longint'(in_ready[0]), 1);
    send(0, 15, 0, 0);
    wait_done(0, lat);
    check("prod_3x15", longint'(out4), 45);
    send(0, 15, 0, 0);
    wait_done(0, lat);
    check("prod_15x15", longint'(out4), 225);

    send(0, 15, 0, 1);
    wait_done(0, lat);
    check("acc_wrap", longint'(out4), 194);
    check("acc_ovf", longint'(ovf[0]), 1);
    pulse_clr(0);
    check("clr_out", longint'(out4), 0);
    check("clr_ovf", longint'(ovf[0]), 0);

    send(0, 7, 0, 0);
    tick(); tick();
    pulse_clr(0);
    repeat (8) tick();
    send(0, 2, 0, 0);
    wait_done(0, lat);
    check("last_kept_after_clr", longint'(out4), 14);

    send(0, 6, 0, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_out", longint'(out4), 0);
    check("rst_mid_ready", longint'(in_ready[0]), 1);
    repeat (8) tick();
    send(0, 4, 0, 0);
    wait_done(0, lat);
    check("rst_last_cleared", longint'(out4), 0);
    send(0, 3, 0, 0);
    wait_done(0, lat);
    check("prod_4x3", longint'(out4), 12);

    send(1, 63, 0, 0);
    wait_done(1, lat);
    check("w6_latency", lat, 7);
    check("w6_prod_0x63", longint'(out6), 0);
    send(1, 63, 0, 0);
    wait_done(1, lat);
    check("w6_prod_63x63", longint'(out6), 3969);
    send(1, 8, 0, 0);
    check("w6_drop_eight", longint'(in_ready[1]), 1);
    send(1, 63, 0, 1);
    wait_done(1, lat);
    check("w6_acc_wrap", longint'(out6), 3842);
    check("w6_acc_ovf", longint'(ovf[1]), 1);
    pulse_clr(1);
    check("w6_clr_out", longint'(out6), 0);
    check("w6_clr_ovf", longint'(ovf[1]), 0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
